// File: rtl/reg_file_pkg.sv
// Shared definitions for the multi-port register file: state encoding,
// default widths and packed-bus slice helper.
package reg_file_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Clear sequencer states
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  // Low bit of lane idx in a packed bus of width-bit lanes
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One read port: zero-register filter, write-bypass priority mux and the
// registered read data output.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_WR   = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic [DATA_W-1:0]        mem_data,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0]        rd_data
);

  logic              is_zero_s;
  logic              hit_s;
  logic [DATA_W-1:0] byp_data_s;
  logic [DATA_W-1:0] next_data_s;
  logic [DATA_W-1:0] rd_data_r;

  assign is_zero_s = (ZERO_REG != 0) && (rd_addr == '0);
  assign rd_data   = rd_data_r;

  // Find the highest-index enabled write hitting this read address
  always_comb begin
    hit_s      = 1'b0;
    byp_data_s = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j] && (wr_addr[slice_lo(j, ADDR_W) +: ADDR_W] == rd_addr)) begin
        hit_s      = 1'b1;
        byp_data_s = wr_data[slice_lo(j, DATA_W) +: DATA_W];
      end else begin
        hit_s      = hit_s;
        byp_data_s = byp_data_s;
      end
    end
  end

  // Select zero, forwarded write data or stored contents
  always_comb begin
    next_data_s = mem_data;
    if (is_zero_s) begin
      next_data_s = '0;
    end else if ((BYPASS != 0) && hit_s) begin
      next_data_s = byp_data_s;
    end else begin
      next_data_s = mem_data;
    end
  end

  // Output register: zero while clearing, capture on enable, else hold
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r <= '0;
    end else if (!run) begin
      rd_data_r <= '0;
    end else if (rd_en) begin
      rd_data_r <= next_data_s;
    end else begin
      rd_data_r <= rd_data_r;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: storage array, write ports, post-reset clear
// sequencer and NUM_RD registered read ports.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic                     ready
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  rf_state_e         state_r;
  logic [ADDR_W-1:0] clr_ptr_r;
  logic              ready_r;
  logic              run_s;
  logic [NUM_WR-1:0] wr_en_s;

  // Writes are only honoured once the clear sequence has finished
  assign run_s   = (state_r == RUN);
  assign wr_en_s = run_s ? wr_en : '0;
  assign ready   = ready_r;

  // Clear sequencer: walk every address once after reset, then run
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= CLEAR;
      clr_ptr_r <= '0;
      ready_r   <= 1'b0;
    end else begin
      case (state_r)
        CLEAR: begin
          clr_ptr_r <= clr_ptr_r + ADDR_W'(1);
          if (clr_ptr_r == ADDR_W'(DEPTH - 1)) begin
            state_r <= RUN;
            ready_r <= 1'b1;
          end else begin
            state_r <= CLEAR;
            ready_r <= 1'b0;
          end
        end
        RUN: begin
          state_r <= RUN;
        end
        default: begin
          state_r   <= CLEAR;
          clr_ptr_r <= '0;
          ready_r   <= 1'b0;
        end
      endcase
    end
  end

  // Storage update: clearing zeros, else ports in order so the highest index wins
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_r == CLEAR) begin
        mem_r[clr_ptr_r] <= '0;
      end else begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_en_s[j] &&
              !((ZERO_REG != 0) && (wr_addr[slice_lo(j, ADDR_W) +: ADDR_W] == '0))) begin
            mem_r[wr_addr[slice_lo(j, ADDR_W) +: ADDR_W]] <= wr_data[slice_lo(j, DATA_W) +: DATA_W];
          end
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [DATA_W-1:0] mem_rd_s;

    assign mem_rd_s = mem_r[rd_addr[slice_lo(i, ADDR_W) +: ADDR_W]];

    reg_file_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NUM_WR  (NUM_WR),
      .BYPASS  (BYPASS),
      .ZERO_REG(ZERO_REG)
    ) u_rd (
      .clk     (clk),
      .rst     (rst),
      .run     (run_s),
      .rd_en   (rd_en[i]),
      .rd_addr (rd_addr[slice_lo(i, ADDR_W) +: ADDR_W]),
      .mem_data(mem_rd_s),
      .wr_en   (wr_en_s),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_data (rd_data[slice_lo(i, DATA_W) +: DATA_W])
    );
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench: two register files (bypass+zero-reg and plain) driven
// in parallel and compared each cycle against an array-based reference model.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  rd_en = 2'b00;
  logic [9:0]  rd_addr = 10'd0;
  logic [1:0]  wr_en = 2'b00;
  logic [9:0]  wr_addr = 10'd0;
  logic [63:0] wr_data = 64'd0;
  logic [63:0] rd_data_a, rd_data_b;
  logic        ready_a, ready_b;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state; config 0 = bypass + zero reg, config 1 = neither
  logic [31:0] mem_m  [2][32];
  logic [31:0] exp_rd [2][2];
  logic        exp_ready;
  int          clr_cnt;

  always #5 clk = ~clk;

  reg_file_mp #(.NUM_WR(2)) dut_a (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .ready(ready_a)
  );

  reg_file_mp #(.NUM_WR(2), .BYPASS(0), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .ready(ready_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Result a read of address a would return this edge under config c
  function automatic logic [31:0] model_read(input int c, input logic [4:0] a);
    logic [31:0] r;
    logic        zr;
    logic        byp;
    zr  = (c == 0);
    byp = (c == 0);
    r   = mem_m[c][a];
    if (zr && a == 5'd0) begin
      r = 32'd0;
    end else if (byp) begin
      for (int j = 0; j < 2; j++)
        if (wr_en[j] && wr_addr[j*5 +: 5] == a) r = wr_data[j*32 +: 32];
    end
    return r;
  endfunction

  // Advance the model by one edge, clock the DUTs, compare all outputs
  task automatic step();
    if (rst) begin
      clr_cnt   = 0;
      exp_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
        for (int a = 0; a < 32; a++) mem_m[c][a] = 32'd0;
        for (int i = 0; i < 2; i++) exp_rd[c][i] = 32'd0;
      end
    end else if (clr_cnt < 32) begin
      clr_cnt++;
      exp_ready = (clr_cnt == 32);
    end else begin
      for (int c = 0; c < 2; c++) begin
        for (int i = 0; i < 2; i++)
          if (rd_en[i]) exp_rd[c][i] = model_read(c, rd_addr[i*5 +: 5]);
        for (int j = 0; j < 2; j++)
          if (wr_en[j] && !(c == 0 && wr_addr[j*5 +: 5] == 5'd0))
            mem_m[c][wr_addr[j*5 +: 5]] = wr_data[j*32 +: 32];
      end
    end
    @(posedge clk);
    #1;
    chk("ready_a", {31'd0, ready_a}, {31'd0, exp_ready});
    chk("ready_b", {31'd0, ready_b}, {31'd0, exp_ready});
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rd_a_p%0d", i), rd_data_a[i*32 +: 32], exp_rd[0][i]);
      chk($sformatf("rd_b_p%0d", i), rd_data_b[i*32 +: 32], exp_rd[1][i]);
    end
  endtask

  task automatic idle();
    rd_en = 2'b00;
    wr_en = 2'b00;
  endtask

  task automatic set_wr(input int p, input logic en, input logic [4:0] a, input logic [31:0] d);
    wr_en[p]          = en;
    wr_addr[p*5 +: 5] = a;
    wr_data[p*32 +: 32] = d;
  endtask

  task automatic set_rd(input int p, input logic en, input logic [4:0] a);
    rd_en[p]          = en;
    rd_addr[p*5 +: 5] = a;
  endtask

  task automatic randomize_ports(input int amax);
    rd_en = 2'($urandom);
    wr_en = 2'($urandom);
    for (int p = 0; p < 2; p++) begin
      rd_addr[p*5 +: 5]   = 5'($urandom_range(0, amax));
      wr_addr[p*5 +: 5]   = 5'($urandom_range(0, amax));
      wr_data[p*32 +: 32] = $urandom;
    end
  endtask

  initial begin
    // Reset and clear, with random traffic that must be ignored
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (32) begin
      randomize_ports(31);
      step();
    end
    chk("ready_after_clear", {31'd0, ready_a}, 32'd1);

    // Every address reads zero after clear
    idle();
    for (int a = 0; a < 32; a += 2) begin
      set_rd(0, 1'b1, 5'(a));
      set_rd(1, 1'b1, 5'(a + 1));
      step();
    end

    // Write then read, then hold with enable low
    idle(); set_wr(0, 1'b1, 5'd7, 32'hDEADBEEF); step();
    idle(); set_rd(0, 1'b1, 5'd7); step();
    chk("r7_read", rd_data_a[31:0], 32'hDEADBEEF);
    idle(); set_rd(0, 1'b0, 5'd12); step();
    chk("r7_hold", rd_data_b[31:0], 32'hDEADBEEF);

    // Zero register versus ordinary r0
    idle(); set_wr(0, 1'b1, 5'd0, 32'h12345678); step();
    idle(); set_rd(0, 1'b1, 5'd0); step();
    chk("r0_zero_reg", rd_data_a[31:0], 32'h00000000);
    chk("r0_plain", rd_data_b[31:0], 32'h12345678);

    // Same-edge write and read of r3
    idle(); set_wr(0, 1'b1, 5'd3, 32'h11111111); step();
    idle(); set_wr(0, 1'b1, 5'd3, 32'h22222222); set_rd(1, 1'b1, 5'd3); step();
    chk("r3_bypass", rd_data_a[63:32], 32'h22222222);
    chk("r3_nobypass", rd_data_b[63:32], 32'h11111111);
    idle(); set_rd(1, 1'b1, 5'd3); step();
    chk("r3_next", rd_data_b[63:32], 32'h22222222);

    // Dual-write conflict on r5 with same-edge read
    idle();
    set_wr(0, 1'b1, 5'd5, 32'hAAAA0000);
    set_wr(1, 1'b1, 5'd5, 32'h0000BBBB);
    set_rd(0, 1'b1, 5'd5);
    step();
    chk("r5_bypass_conflict", rd_data_a[31:0], 32'h0000BBBB);
    idle(); set_rd(0, 1'b1, 5'd5); step();
    chk("r5_stored_conflict", rd_data_b[31:0], 32'h0000BBBB);

    // Random traffic over a narrow address range to force collisions
    repeat (300) begin
      randomize_ports(7);
      step();
    end

    // Reset in the middle of operation
    idle(); set_wr(0, 1'b1, 5'd9, 32'h00000055); step();
    idle(); repeat (8) step();
    rst = 1'b1; step();
    chk("ready_drop", {31'd0, ready_b}, 32'd0);
    rst = 1'b0;
    repeat (32) begin
      idle();
      set_wr(0, 1'b1, 5'd9, $urandom);
      set_wr(1, 1'b1, 5'd0, $urandom);
      set_rd(0, 1'b1, 5'd9);
      step();
    end
    idle(); set_rd(0, 1'b1, 5'd9); set_rd(1, 1'b1, 5'd0); step();
    chk("r9_cleared", rd_data_b[31:0], 32'h00000000);
    chk("r0_cleared", rd_data_b[63:32], 32'h00000000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port register file for the pipelined MIPS core and wider-issue successors. Provides NUM_RD synchronous read ports and NUM_WR write ports, all on the rising edge of clk. Supports configurable write-to-read bypass, an optional hardwired-zero register and a post-reset clear sequencer. Sits in ID stage: read ports feed operand registers, write ports are driven from WB.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
NUM_RD, 2, number of read ports (1..4)
NUM_WR, 1, number of write ports (1..2)
BYPASS, 1, 1 = same-cycle write data forwarded to matching read; 0 = read returns old contents
ZERO_REG, 1, 1 = address 0 reads as 0 and ignores writes

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
rd_en  in  NUM_RD  per-port read enable
rd_addr  in  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  registered read data; port i at bits [i*DATA_W +: DATA_W]
wr_en  in  NUM_WR  per-port write enable
wr_addr  in  NUM_WR*ADDR_W  write addresses, same packing
wr_data  in  NUM_WR*DATA_W  write data, same packing
ready  out  1  high when clear sequence done and ports accepted

Behaviour:
- Reset: synchronous active-high on clk and rst. When rst is high at a rising edge: state <= CLEAR, clr_ptr <= 0, ready <= 0, all rd_data <= 0. rst asserted mid-CLEAR or mid-operation restarts the clear from address 0.
- States: CLEAR, RUN.
- CLEAR: each cycle writes 0 to mem[clr_ptr], clr_ptr++. At clr_ptr == DEPTH-1 the write happens and state <= RUN, ready <= 1. CLEAR lasts exactly DEPTH cycles after rst deasserts. wr_en is ignored. rd_data is held at 0.
- RUN: stays in RUN until rst.
- Write (RUN): wr_en[j] high at a rising edge writes wr_data[j] to mem[wr_addr[j]]. ZERO_REG=1 drops writes to address 0.
- Write conflict: two ports enabled to the same address; the higher port index wins.
- Read (RUN): if rd_en[i] is high at edge N, rd_data[i] holds the result from edge N on, so latency is 1 cycle. If rd_en[i] is low, rd_data[i] holds its previous value.
- Read result:
  - ZERO_REG=1 and address 0: returns 0.
  - BYPASS=1 and an enabled same-edge write matches the address (after the zero filter): returns that write's data, using the highest matching write port.
  - Otherwise: returns mem contents before this edge's writes.
- Several read ports may read the same address in one cycle; each is resolved independently.
- Read and write of different addresses in the same cycle do not interact.
- No X-propagation: all mem entries are defined after CLEAR.

Decomposition:
- Shared package reg_file_pkg:
  - state enum with values CLEAR, RUN
  - default width constants DATA_W_DEF=32, ADDR_W_DEF=5
  - function for packed-bus slice indexing
- One natural sub-module: reg_file_rd_port, instantiated NUM_RD times in a generate loop. It holds the per-port zero filter, bypass priority mux and output register.
- Storage array, write logic and clear FSM stay in the top module.

Test Plan:
- Reset/clear (defaults): pulse rst 1 cycle. Required: ready=0 for exactly 32 cycles, then 1. Reading every address then returns 0x00000000. rd_data=0 throughout CLEAR.
- Write then read: write 0xDEADBEEF to r7, next cycle rd_addr0=7 with rd_en0=1. Required: rd_data0=0xDEADBEEF one cycle later. Then drop rd_en0 and change rd_addr0: rd_data0 holds 0xDEADBEEF.
- Zero register (ZERO_REG=1): write 0x12345678 to r0. Required: reads of r0 return 0.
- Zero register (ZERO_REG=0): same write. Required: read of r0 returns 0x12345678.
- Bypass (r3 previously 0x11111111; same edge: write 0x22222222 to r3, read r3):
  - BYPASS=1: rd_data=0x22222222.
  - BYPASS=0: rd_data=0x11111111, and the next read returns 0x22222222.
- Dual-write conflict (NUM_WR=2): both ports write r5, port0 0xAAAA0000, port1 0x0000BBBB. Required: a later read of r5 returns 0x0000BBBB. A same-edge bypassed read also returns 0x0000BBBB.
- Reset mid-operation: after writing r9=0x55, assert rst at cycle 10 of RUN. Required: ready drops next edge, stays 0 for 32 cycles after rst release, and r9 then reads 0. A wr_en during CLEAR leaves its address at 0.
